tl_a_channel_slave: RTL and testbench



---
 rtl/tl_a_channel_slave.sv | 149 ++++++++++++++
 tb/tb_tl_a_channel_slave.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_channel_slave.sv
// TileLink-UL A-channel slave: writes PutFullData bursts to local memory and pushes a
// 37-bit response request per completed request. Optional macro: TL_A_ERR_CNT_EN.
module tl_a_channel_slave #(
    parameter int band_width = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_size,
    input  logic [3:0]  a_mark,
    input  logic [31:0] a_address,
    input  logic [63:0] a_data,
    output logic        o_wen,
    output logic [31:0] o_write_address,
    output logic [63:0] o_wdata,
    input  logic        i_full_FIFO_request,
    output logic        o_push_FIFO_request,
    output logic [36:0] o_write_request,
`ifdef TL_A_ERR_CNT_EN
    output logic [7:0]  o_err_cnt,
`endif
    output logic [1:0]  state_dbg
);

    // Handshake: a beat transfers on a rising clk edge where a_valid && a_ready;
    // a_ready never looks at a_valid, and a_valid may drop between burst beats.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BURST = 2'd1,
        PUSH        = 2'd2
    } state_t;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [4:0]  beats_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  mark_q;

    logic        accept;
    logic        is_put;
    logic        is_get;
    logic [4:0]  first_beats;
    logic        last_beat;

    function automatic logic [4:0] beats_of(input logic [2:0] sz);
        int s;
        s = int'(sz);
        if (s > band_width) return 5'(1 << (s - band_width));
        else return 5'd1;
    endfunction

    assign accept      = a_valid && a_ready;
    assign is_put      = (a_opcode == OP_PUT_FULL);
    assign is_get      = (a_opcode == OP_GET);
    assign first_beats = beats_of(a_size);
    assign last_beat   = (state_q == WRITE_BURST) && (cnt_q == beats_q - 5'd1);
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_get)      state_d = PUSH;
                    else if (is_put) state_d = (first_beats == 5'd1) ? PUSH : WRITE_BURST;
                end
            end
            WRITE_BURST: if (accept && last_beat) state_d = PUSH;
            PUSH:        if (!i_full_FIFO_request) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // A burst in flight never waits on the FIFO; only new requests and the push do.
    always_comb begin
        a_ready = 1'b0;
        case (state_q)
            IDLE:        a_ready = !i_full_FIFO_request;
            WRITE_BURST: a_ready = 1'b1;
            default:     a_ready = 1'b0;
        endcase
        o_wen               = accept && (((state_q == IDLE) && is_put) || (state_q == WRITE_BURST));
        o_wdata             = a_data;
        o_push_FIFO_request = (state_q == PUSH) && !i_full_FIFO_request;
        o_write_address     = 32'd0;
        if (o_wen) begin
            if (state_q == IDLE) o_write_address = a_address;
            else                 o_write_address = addr_q + (32'(cnt_q) << band_width);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= 5'd0;
            beats_q         <= 5'd0;
            addr_q          <= 32'd0;
            size_q          <= 3'd0;
            mark_q          <= 4'd0;
            o_write_request <= 37'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        size_q  <= a_size;
                        mark_q  <= a_mark;
                        addr_q  <= a_address;
                        beats_q <= first_beats;
                        if (is_get)
                            o_write_request <= {3'd1, a_size, a_mark, a_address[31:5]};
                        else if (is_put && first_beats == 5'd1)
                            o_write_request <= {3'd0, a_size, a_mark, a_address[31:5]};
                        else if (is_put)
                            cnt_q <= 5'd1;
                    end
                end
                WRITE_BURST: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (last_beat)
                            o_write_request <= {3'd0, size_q, mark_q, addr_q[31:5]};
                    end
                end
                PUSH: if (!i_full_FIFO_request) cnt_q <= 5'd0;
                default: cnt_q <= 5'd0;
            endcase
        end
    end

`ifdef TL_A_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_err_cnt <= 8'd0;
        else if ((state_q == IDLE) && accept && !is_put && !is_get && (o_err_cnt != 8'hFF))
            o_err_cnt <= o_err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tl_a_channel_slave.sv
// Bench for tl_a_channel_slave: directed steps then randomized requests, checked against
// a request-level model (expected write and push queues).
module tb_tl_a_channel_slave;
    localparam int BW = 3;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_mark;
    logic [31:0] a_address;
    logic [63:0] a_data;
    logic        o_wen;
    logic [31:0] o_write_address;
    logic [63:0] o_wdata;
    logic        full;
    logic        o_push;
    logic [36:0] o_write_request;
    logic [1:0]  state_dbg;
`ifdef TL_A_ERR_CNT_EN
    logic [7:0]  o_err_cnt;
`endif

    int tests, fails;
    logic [95:0] exp_wq[$];
    logic [36:0] exp_pq[$];
    int wr_seen, wr_exp, push_seen, push_exp, err_exp;
    bit rand_full;

    tl_a_channel_slave #(.band_width(BW)) dut (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(a_ready),
        .a_opcode(a_opcode), .a_size(a_size), .a_mark(a_mark), .a_address(a_address),
        .a_data(a_data), .o_wen(o_wen), .o_write_address(o_write_address), .o_wdata(o_wdata),
        .i_full_FIFO_request(full), .o_push_FIFO_request(o_push),
        .o_write_request(o_write_request),
`ifdef TL_A_ERR_CNT_EN
        .o_err_cnt(o_err_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every observed write / push must match the head of its expected queue
    task automatic monitor();
        logic [95:0] w;
        logic [36:0] p;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (o_wen === 1'b1) begin
                    wr_seen++;
                    chk("wen_with_accept", 128'(a_valid && a_ready), 128'(1));
                    if (exp_wq.size() == 0) begin
                        tests++; fails++;
                        $error("FAIL unexpected_write observed=%0h expected=none", {o_write_address, o_wdata});
                    end else begin
                        w = exp_wq.pop_front();
                        chk("write_addr_data", 128'({o_write_address, o_wdata}), 128'(w));
                    end
                end
                if (o_push === 1'b1) begin
                    push_seen++;
                    if (exp_pq.size() == 0) begin
                        tests++; fails++;
                        $error("FAIL unexpected_push observed=%0h expected=none", o_write_request);
                    end else begin
                        p = exp_pq.pop_front();
                        chk("push_header", 128'(o_write_request), 128'(p));
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_full) full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] mk,
                             input logic [31:0] ad, input logic [63:0] d);
        a_opcode = op; a_size = sz; a_mark = mk; a_address = ad; a_data = d;
        a_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_ready) begin
                cyc();
                a_valid = 1'b0;
                return;
            end
            cyc();
        end
        tests++; fails++;
        $error("FAIL accept_timeout observed=no_ready expected=accept");
        a_valid = 1'b0;
    endtask

    // model: a PutFull of 2^size bytes is ceil(bytes/8) beats at addr + 8*i
    task automatic send_req(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] mk,
                            input logic [31:0] ad, input bit seq, input int gap_at, input int gap_len);
        int n;
        logic [63:0] d[16];
        n = 1;
        if (op == 3'd0 && int'(sz) > BW) n = 1 << (int'(sz) - BW);
        for (int i = 0; i < n; i++) d[i] = seq ? 64'(i + 1) : {$urandom, $urandom};
        if (op == 3'd0) begin
            for (int i = 0; i < n; i++) exp_wq.push_back({ad + 32'(i * 8), d[i]});
            exp_pq.push_back({3'd0, sz, mk, ad[31:5]});
            wr_exp += n;
            push_exp++;
        end else if (op == 3'd4) begin
            exp_pq.push_back({3'd1, sz, mk, ad[31:5]});
            push_exp++;
        end else if (err_exp < 255) begin
            err_exp++;
        end
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (gap_len) cyc();
            if (i == 0) send_beat(op, sz, mk, ad, d[i]);
            else send_beat(3'($urandom), 3'($urandom), 4'($urandom), $urandom, d[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ready"}, 128'(a_ready), 128'(1));
        chk({tag, "_wen"}, 128'(o_wen), 128'(0));
        chk({tag, "_waddr"}, 128'(o_write_address), 128'(0));
        chk({tag, "_wdata"}, 128'(o_wdata), 128'(a_data));
        chk({tag, "_push"}, 128'(o_push), 128'(0));
        chk({tag, "_wreq"}, 128'(o_write_request), 128'(0));
`ifdef TL_A_ERR_CNT_EN
        chk({tag, "_err_cnt"}, 128'(o_err_cnt), 128'(0));
`endif
    endtask

    initial begin
        logic [2:0] bad_ops[6];
        logic [36:0] hdr;
        int r;
        bad_ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        tests = 0; fails = 0;
        wr_seen = 0; wr_exp = 0; push_seen = 0; push_exp = 0; err_exp = 0;
        rand_full = 1'b0;
        rst_n = 1'b0; full = 1'b0; a_valid = 1'b0;
        a_opcode = 3'd0; a_size = 3'd0; a_mark = 4'd0; a_address = 32'd0;
        a_data = 64'h1234_5678_9ABC_DEF0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork monitor(); join_none
        full = 1'b1;
        @(negedge clk);
        chk("idle_ready_follows_full", 128'(a_ready), 128'(0));
        @(posedge clk); #1;
        full = 1'b0;

        // Get: push one cycle after accept, no write
        send_req(3'd4, 3'd3, 4'hA, 32'h0000_1000, 1'b0, -1, 0);
        @(negedge clk);
        chk("get_push_latency", 128'(o_push), 128'(1));
        chk("get_header", 128'(o_write_request), 128'({3'd1, 3'd3, 4'hA, 27'h80}));
        @(posedge clk); #1;

        // 4-beat PutFull, data 1..4
        send_req(3'd0, 3'd5, 4'h3, 32'h0000_2000, 1'b1, -1, 0);
        @(negedge clk);
        chk("put4_push", 128'(o_push), 128'(1));
        chk("put4_header", 128'(o_write_request), 128'({3'd0, 3'd5, 4'h3, 27'h100}));
        @(posedge clk); #1;
        chk("put4_writes_done", 128'(exp_wq.size()), 128'(0));

        // 8-beat PutFull with a 2-cycle valid gap mid-burst
        send_req(3'd0, 3'd6, 4'h7, 32'h0000_4100, 1'b0, 3, 2);
        repeat (2) cyc();
        chk("put8_write_count", 128'(wr_seen), 128'(12));
        chk("put8_push_count", 128'(push_seen), 128'(3));

        // address wraps at 2^32
        send_req(3'd0, 3'd5, 4'h1, 32'hFFFF_FFF0, 1'b0, -1, 0);
        repeat (2) cyc();

        // FIFO full around a Get
        hdr = {3'd1, 3'd2, 4'h5, 27'(32'hABCD_EF00 >> 5)};
        exp_pq.push_back(hdr);
        push_exp++;
        full = 1'b1;
        a_opcode = 3'd4; a_size = 3'd2; a_mark = 4'h5; a_address = 32'hABCD_EF00;
        a_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_idle_stall", 128'(a_ready), 128'(0));
            @(posedge clk); #1;
        end
        full = 1'b0;
        @(negedge clk);
        chk("full_release_ready", 128'(a_ready), 128'(1));
        @(posedge clk); #1;
        a_valid = 1'b0;
        full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_push_wait", 128'(o_push), 128'(0));
            chk("full_header_stable", 128'(o_write_request), 128'(hdr));
            chk("full_push_no_ready", 128'(a_ready), 128'(0));
            @(posedge clk); #1;
        end
        full = 1'b0;
        @(negedge clk);
        chk("full_push_fires", 128'(o_push), 128'(1));
        chk("full_push_header", 128'(o_write_request), 128'(hdr));
        @(posedge clk); #1;

        // reset after beat 2 of a 4-beat PutFull
        exp_wq.push_back({32'h0000_3000, 64'hAAAA_0001});
        exp_wq.push_back({32'h0000_3008, 64'hAAAA_0002});
        wr_exp += 2;
        send_beat(3'd0, 3'd5, 4'h9, 32'h0000_3000, 64'hAAAA_0001);
        send_beat(3'd0, 3'd5, 4'h9, 32'h0000_3000, 64'hAAAA_0002);
        rst_n = 1'b0;
        err_exp = 0;
        @(negedge clk);
        check_reset_outputs("midburst_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_no_push", 128'(o_push), 128'(0));
        @(posedge clk); #1;
        send_req(3'd4, 3'd4, 4'hC, 32'h0000_5040, 1'b0, -1, 0);
        @(negedge clk);
        chk("post_reset_get_push", 128'(o_push), 128'(1));
        chk("post_reset_get_header", 128'(o_write_request), 128'({3'd1, 3'd4, 4'hC, 27'h282}));
        @(posedge clk); #1;

        // unsupported opcodes are dropped
        repeat (3) begin
            send_req(3'd2, 3'd3, 4'h2, 32'h0000_6000, 1'b0, -1, 0);
            @(negedge clk);
            chk("unsupported_ready", 128'(a_ready), 128'(1));
            chk("unsupported_no_push", 128'(o_push), 128'(0));
            @(posedge clk); #1;
        end
`ifdef TL_A_ERR_CNT_EN
        chk("err_cnt_three", 128'(o_err_cnt), 128'(3));
`endif

        // randomized requests with random FIFO backpressure and valid gaps
        rand_full = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5)
                send_req(3'd0, 3'($urandom_range(0, 7)), 4'($urandom), $urandom, 1'b0,
                         $urandom_range(1, 8), $urandom_range(0, 2));
            else if (r < 8)
                send_req(3'd4, 3'($urandom_range(0, 7)), 4'($urandom), $urandom, 1'b0, -1, 0);
            else
                send_req(bad_ops[$urandom_range(0, 5)], 3'($urandom), 4'($urandom), $urandom,
                         1'b0, -1, 0);
        end
        rand_full = 1'b0;
        full = 1'b0;
        repeat (5) cyc();

        chk("final_write_count", 128'(wr_seen), 128'(wr_exp));
        chk("final_push_count", 128'(push_seen), 128'(push_exp));
        chk("final_write_queue_empty", 128'(exp_wq.size()), 128'(0));
        chk("final_push_queue_empty", 128'(exp_pq.size()), 128'(0));
`ifdef TL_A_ERR_CNT_EN
        chk("final_err_cnt", 128'(o_err_cnt), 128'(err_exp));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
